// File: rtl/xor_decoding_stream.sv
// xor_decoding_stream: receive-side decoder for the 80-bit XOR-encrypted frame.
// Bytes arrive on a valid/ready stream. Each byte is XORed with a rotating key
// byte and assembled into a shadow frame. The finished plaintext frame is then
// presented downstream with its own valid/ready handshake.
// Optional feature macro: CHECKSUM_EN. When it is defined, each frame carries an
// 11th byte that is checked against the XOR of the ten plaintext bytes.
module xor_decoding_stream #(
    parameter int FRAME_BYTES = 10,
    parameter int KEY_BYTES   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_load,
    input  logic [0:8*KEY_BYTES-1]     final_key,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [0:7]                 in_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [0:8*FRAME_BYTES-1]   data_out,
    output logic                       frame_err
);

`ifdef CHECKSUM_EN
    localparam int LAST_IDX = FRAME_BYTES;      // checksum byte follows the data
`else
    localparam int LAST_IDX = FRAME_BYTES - 1;
`endif
    localparam int IDX_W = $clog2(FRAME_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_next;
    logic [0:8*KEY_BYTES-1]      key_reg;
    logic [0:8*FRAME_BYTES-1]    shadow;
    logic [0:8*FRAME_BYTES-1]    frame_next;
    logic [0:7]                  key_byte;
    logic [0:7]                  dec_byte;
    logic                        byte_xfer;
    logic                        frame_xfer;
    logic                        last_xfer;

    // Handshake outputs derive from the state and are forced low while reset is high.
    assign in_ready   = !rst && (state != HOLD);
    assign out_valid  = !rst && (state == HOLD);
    assign byte_xfer  = in_valid && in_ready;
    assign frame_xfer = out_valid && out_ready;
    assign last_xfer  = byte_xfer && (state == RECV) && (idx == LAST);

    // Select the key byte for the current position (index mod KEY_BYTES) and decode.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (int'(idx) % KEY_BYTES == k) begin
                key_byte = key_reg[8*k +: 8];
            end
        end
        dec_byte = in_byte ^ key_byte;
    end

    // Merge the decoded byte into its slot. The checksum index has no slot, so it leaves the frame unchanged.
    always_comb begin
        frame_next = shadow;
        if (byte_xfer) begin
            for (int s = 0; s < FRAME_BYTES; s++) begin
                if (int'(idx) == s) begin
                    frame_next[8*s +: 8] = dec_byte;
                end
            end
        end
    end

    // State and byte-index register.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values;
        // blocking = here would let later reads in this block see the new value.
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state and index logic.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (byte_xfer) begin
                    state_next = RECV;
                    idx_next   = IDX_W'(1);
                end
            end
            RECV: begin
                if (byte_xfer) begin
                    if (idx == LAST) begin
                        state_next = HOLD;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (frame_xfer) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Key register: loads only in IDLE. A byte decoded in the same cycle still uses the old key.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
        end else if (key_load && (state == IDLE)) begin
            key_reg <= final_key;
        end
    end

    // Shadow frame assembly.
    always_ff @(posedge clk) begin
        // NOTE: the shadow has no reset. Every slot is rewritten before the frame is
        // copied to data_out, so stale contents are never observable.
        if (byte_xfer) begin
            shadow <= frame_next;
        end
    end

    // Published frame: updated only on the final byte, so partial frames never appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (last_xfer) begin
            data_out <= frame_next;
        end
    end

`ifdef CHECKSUM_EN
    logic [0:7] chk_acc;

    // Running XOR of the plaintext data bytes, and the error flag captured on the checksum byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_acc   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (byte_xfer && (int'(idx) < FRAME_BYTES)) begin
                chk_acc <= (idx == '0) ? dec_byte : (chk_acc ^ dec_byte);
            end
            if (last_xfer) begin
                frame_err <= (dec_byte != chk_acc);
            end else if (frame_xfer) begin
                frame_err <= 1'b0;
            end
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_xor_decoding_stream.sv
// Self-checking bench for xor_decoding_stream.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on the
// falling edge. Completed frames are checked against a queue of expected results.
module tb_xor_decoding_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [0:63] final_key;
    logic        in_valid;
    logic        in_ready;
    logic [0:7]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [0:79] data_out;
    logic        frame_err;

    always #5 clk = ~clk;

    xor_decoding_stream dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .final_key (final_key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [63:0] key;
        logic [7:0]  enc [10];
        logic [7:0]  chk;
        logic [79:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [79:0] data;
        logic        err;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;

`ifdef CHECKSUM_EN
    localparam int CYCLES_PER_FRAME = 12;
`else
    localparam int CYCLES_PER_FRAME = 11;
`endif

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.data = v.data;
`ifdef CHECKSUM_EN
        e.err = v.err;
`else
        e.err = 1'b0;
`endif
        sb.push_back(e);
        pushed++;
    endtask

    // Hold one byte on the stream until it is accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: byte %h never accepted", b);
        end
    endtask

    // mode 0: keep the current key, 1: load the key first, 2: load the key together with byte 0.
    task automatic send_frame(input vec_t v, input int mode, input int gap);
        if (mode == 1) begin
            key_load  = 1'b1;
            final_key = v.key;
            tick();
            key_load  = 1'b0;
        end
        push(v);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) repeat (gap) tick();
            if (i == 0 && mode == 2) begin
                key_load  = 1'b1;
                final_key = v.key;
            end
            send_byte(v.enc[i]);
            key_load = 1'b0;
        end
`ifdef CHECKSUM_EN
        repeat (gap) tick();
        send_byte(v.chk);
`endif
        @(negedge clk);
        check("latency_out_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) tick();
        check("drain_timeout", sb.size(), 0);
        tick();
    endtask

    // Scoreboard: compare each handshaken frame against the next expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got %h expected none", data_out);
            end else begin
                e = sb.pop_front();
                popped++;
                check("frame_data", data_out, e.data);
                check("frame_err", frame_err, e.err);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vec_t sc;
        time  t0;

        vecs[0].key = 64'h0123456789ABCDEF;
        vecs[0].enc = '{8'h01, 8'h22, 8'h47, 8'h64, 8'h8D, 8'hAE, 8'hCB, 8'hE8, 8'h09, 8'h2A};
        vecs[0].chk = 8'h44;  vecs[0].data = 80'h00010203040506070809; vecs[0].err = 1'b0;
        vecs[1] = vecs[0];
        vecs[1].chk = 8'h45;  vecs[1].err = 1'b1;
        vecs[2].key = 64'hFFFFFFFFFFFFFFFF;
        vecs[2].enc = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].chk = 8'hFF;  vecs[2].data = 80'hFFFFFFFFFFFFFFFFFFFF; vecs[2].err = 1'b0;
        vecs[3].key = 64'h0;
        vecs[3].enc = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[3].chk = 8'hBB;  vecs[3].data = 80'hA55A3CC30FF011223344; vecs[3].err = 1'b0;
        vecs[4].key = 64'h1122334455667788;
        vecs[4].enc = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h11, 8'h22};
        vecs[4].chk = 8'h00;  vecs[4].data = 80'h0;                    vecs[4].err = 1'b1;

        // Same-cycle key load: byte 0 uses old key 0x01.., bytes 1..9 use the all-ones key.
        sc.key = 64'hFFFFFFFFFFFFFFFF;
        sc.enc = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        sc.chk = 8'hFF;  sc.data = 80'h0;  sc.err = 1'b0;

        rst = 1'b1; key_load = 1'b0; final_key = '0; in_valid = 1'b0;
        in_byte = '0; out_ready = 1'b1;

        // Reset state.
        repeat (2) tick();
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_data_out", data_out, 0);
        check("reset_frame_err", frame_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v], 1, 0);
            wait_drain();
        end

        // Throughput: back-to-back frames with the same key.
        send_frame(vecs[4], 1, 0);
        t0 = $time;
        send_frame(vecs[4], 0, 0);
        check("throughput_cycles", int'(($time - t0) / 10), CYCLES_PER_FRAME);
        wait_drain();

        // Backpressure: the frame is held for 5 cycles while in_valid is high.
        out_ready = 1'b0;
        send_frame(vecs[0], 1, 0);
        in_valid = 1'b1;
        in_byte  = vecs[0].enc[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_data_out", data_out, vecs[0].data);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_frame(vecs[0], 0, 0);
        wait_drain();

        // Bubbles, with an ignored key_load during RECV.
        push(vecs[0]);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                key_load  = 1'b1;
                final_key = '1;
                tick();
                key_load  = 1'b0;
            end
            send_byte(vecs[0].enc[i]);
            repeat (2) tick();
        end
`ifdef CHECKSUM_EN
        send_byte(vecs[0].chk);
`endif
        wait_drain();
        send_frame(vecs[0], 0, 0);  // key must still be the original one
        wait_drain();

        // Reset mid-frame: partial frame and key are discarded.
        for (int i = 0; i < 4; i++) send_byte(vecs[2].enc[i]);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_data_out", data_out, 0);
        check("midreset_frame_err", frame_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_release_ready", in_ready, 1);
        check("midreset_release_valid", out_valid, 0);
        @(posedge clk); #1;
        send_frame(vecs[3], 0, 0);  // cleared key: plaintext equals ciphertext
        wait_drain();
        send_frame(vecs[4], 1, 0);
        wait_drain();

        // Same-cycle key_load with the first byte.
        send_frame(vecs[0], 1, 0);
        wait_drain();
        send_frame(sc, 2, 0);
        wait_drain();

        check("frame_count", popped, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
